mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way round-robin arbiter onto one tagged memory port; load completions are
// routed back to whichever requester owns the returned tag.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
    parameter int TAG_W = 4,
    parameter int XW    = `XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_command_0,
    input  logic [XW-1:0]    req_addr_0,
    input  logic [63:0]      req_data_0,
    input  logic [1:0]       req_size_0,
    input  logic [1:0]       req_command_1,
    input  logic [XW-1:0]    req_addr_1,
    input  logic [63:0]      req_data_1,
    input  logic [1:0]       req_size_1,
    input  logic [1:0]       req_command_2,
    input  logic [XW-1:0]    req_addr_2,
    input  logic [63:0]      req_data_2,
    input  logic [1:0]       req_size_2,
    output logic [TAG_W-1:0] rsp_response_0,
    output logic [TAG_W-1:0] rsp_response_1,
    output logic [TAG_W-1:0] rsp_response_2,
    output logic [TAG_W-1:0] rsp_tag_0,
    output logic [TAG_W-1:0] rsp_tag_1,
    output logic [TAG_W-1:0] rsp_tag_2,
    output logic [63:0]      rsp_data_0,
    output logic [63:0]      rsp_data_1,
    output logic [63:0]      rsp_data_2,
    output logic [1:0]       proc2mem_command,
    output logic [XW-1:0]    proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic [1:0]       proc2mem_size,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output logic [3:0]       outstanding,
    output logic             spurious_tag
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] HOLD     = 1'b1;
    localparam int         NTAG     = 1 << TAG_W;

    logic [1:0]       cmd  [3];
    logic [XW-1:0]    addr [3];
    logic [63:0]      data [3];
    logic [1:0]       size [3];
    logic [TAG_W-1:0] rsp_response_arr [3];
    logic [TAG_W-1:0] rsp_tag_arr      [3];

    assign cmd[0] = req_command_0;  assign addr[0] = req_addr_0;
    assign data[0] = req_data_0;    assign size[0] = req_size_0;
    assign cmd[1] = req_command_1;  assign addr[1] = req_addr_1;
    assign data[1] = req_data_1;    assign size[1] = req_size_1;
    assign cmd[2] = req_command_2;  assign addr[2] = req_addr_2;
    assign data[2] = req_data_2;    assign size[2] = req_size_2;

    logic [0:0]      state_reg, state_next;
    logic [1:0]      grant_idx_reg, grant_idx_next;
    logic [1:0]      last_idx_reg, last_idx_next;
    logic [NTAG-1:0] valid_reg, valid_next;
    logic [1:0]      owner_mem [NTAG];
    logic [3:0]      outstanding_reg, outstanding_next;
    logic            spurious_reg;

    logic            grant_valid;
    logic [1:0]      grant, cand0, cand1, cand2;
    logic [1:0]      grant_cmd, comp_owner;
    logic            accept, alloc, alloc_new, comp_hit, comp_miss;

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign cand0 = rr_next(last_idx_reg);
    assign cand1 = rr_next(cand0);
    assign cand2 = last_idx_reg;

    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'd0;
        if (state_reg == HOLD) begin
            grant_valid = 1'b1;
            grant       = grant_idx_reg;
        end else if (cmd[cand0] != BUS_NONE) begin
            grant_valid = 1'b1;
            grant       = cand0;
        end else if (cmd[cand1] != BUS_NONE) begin
            grant_valid = 1'b1;
            grant       = cand1;
        end else if (cmd[cand2] != BUS_NONE) begin
            grant_valid = 1'b1;
            grant       = cand2;
        end
    end

    assign grant_cmd = grant_valid ? cmd[grant] : BUS_NONE;
    assign accept    = (grant_cmd != BUS_NONE) && (mem2proc_response != '0);
    assign alloc     = accept && (grant_cmd == BUS_LOAD);

    assign proc2mem_command = grant_cmd;
    assign proc2mem_addr    = (grant_cmd != BUS_NONE) ? addr[grant] : '0;
    assign proc2mem_data    = (grant_cmd != BUS_NONE) ? data[grant] : '0;
    assign proc2mem_size    = (grant_cmd != BUS_NONE) ? size[grant] : '0;

    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        last_idx_next  = last_idx_reg;
        if (accept) begin
            state_next    = IDLE;
            last_idx_next = grant;
        end else if (grant_cmd != BUS_NONE) begin
            state_next     = HOLD;
            grant_idx_next = grant;
        end else begin
            state_next = IDLE;
        end
    end

    assign comp_owner = owner_mem[mem2proc_tag];
    assign comp_hit   = (mem2proc_tag != '0) && valid_reg[mem2proc_tag];
    assign comp_miss  = (mem2proc_tag != '0) && !valid_reg[mem2proc_tag];
    // Only count an allocation that lands on a tag left free after this cycle's completion.
    assign alloc_new  = alloc && !(valid_reg[mem2proc_response] &&
                                   !(comp_hit && (mem2proc_tag == mem2proc_response)));

    always_comb begin
        valid_next = valid_reg;
        if (comp_hit)
            valid_next[mem2proc_tag] = 1'b0;
        if (alloc)
            valid_next[mem2proc_response] = 1'b1;
        valid_next[0] = 1'b0;
        outstanding_next = outstanding_reg + 4'(alloc_new) - 4'(comp_hit);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= IDLE;
            grant_idx_reg   <= 2'd0;
            last_idx_reg    <= 2'd2;
            valid_reg       <= '0;
            outstanding_reg <= '0;
            spurious_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_idx_reg   <= grant_idx_next;
            last_idx_reg    <= last_idx_next;
            valid_reg       <= valid_next;
            outstanding_reg <= outstanding_next;
            spurious_reg    <= spurious_reg | comp_miss;
        end
    end

    // Owner entries are meaningless while their valid bit is clear, so they need no reset.
    always_ff @(posedge clock) begin
        if (alloc)
            owner_mem[mem2proc_response] <= grant;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rsp
        assign rsp_response_arr[gi] = (accept && grant == 2'(gi)) ? mem2proc_response : '0;
        assign rsp_tag_arr[gi]      = (comp_hit && comp_owner == 2'(gi)) ? mem2proc_tag : '0;
    end

    assign rsp_response_0 = rsp_response_arr[0];
    assign rsp_response_1 = rsp_response_arr[1];
    assign rsp_response_2 = rsp_response_arr[2];
    assign rsp_tag_0      = rsp_tag_arr[0];
    assign rsp_tag_1      = rsp_tag_arr[1];
    assign rsp_tag_2      = rsp_tag_arr[2];
    assign rsp_data_0     = mem2proc_data;
    assign rsp_data_1     = mem2proc_data;
    assign rsp_data_2     = mem2proc_data;
    assign outstanding    = outstanding_reg;
    assign spurious_tag   = spurious_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, every cycle compared
// against a transaction-level model (pending requests, owner map, sticky flag).
module tb_mem_arbiter;

    localparam int TAG_W = 4;
    localparam int XW    = 32;
    localparam int NTAG  = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       cmd  [3];
    logic [XW-1:0]    addr [3];
    logic [63:0]      data [3];
    logic [1:0]       size [3];
    logic [TAG_W-1:0] mem_resp, mem_tag;
    logic [63:0]      mem_data;
    logic [TAG_W-1:0] rsp_response [3];
    logic [TAG_W-1:0] rsp_tag      [3];
    logic [63:0]      rsp_data     [3];
    logic [1:0]       proc2mem_command, proc2mem_size;
    logic [XW-1:0]    proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [3:0]       outstanding;
    logic             spurious_tag;

    // model state
    int m_last, m_lock;
    bit m_valid [NTAG];
    int m_owner [NTAG];
    bit m_spur;
    bit done [3];
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.TAG_W(TAG_W), .XW(XW)) dut (
        .clock(clock), .reset(reset),
        .req_command_0(cmd[0]), .req_addr_0(addr[0]), .req_data_0(data[0]), .req_size_0(size[0]),
        .req_command_1(cmd[1]), .req_addr_1(addr[1]), .req_data_1(data[1]), .req_size_1(size[1]),
        .req_command_2(cmd[2]), .req_addr_2(addr[2]), .req_data_2(data[2]), .req_size_2(size[2]),
        .rsp_response_0(rsp_response[0]), .rsp_response_1(rsp_response[1]),
        .rsp_response_2(rsp_response[2]),
        .rsp_tag_0(rsp_tag[0]), .rsp_tag_1(rsp_tag[1]), .rsp_tag_2(rsp_tag[2]),
        .rsp_data_0(rsp_data[0]), .rsp_data_1(rsp_data[1]), .rsp_data_2(rsp_data[2]),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem_resp), .mem2proc_data(mem_data), .mem2proc_tag(mem_tag),
        .outstanding(outstanding), .spurious_tag(spurious_tag)
    );

    task automatic check_value(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 2;
        m_lock = -1;
        m_spur = 0;
        foreach (m_valid[t]) m_valid[t] = 0;
    endtask

    // Locked requester if any, else first active one after the last winner.
    function automatic int model_grant();
        int k;
        if (m_lock >= 0) return m_lock;
        for (int i = 1; i <= 3; i++) begin
            k = (m_last + i) % 3;
            if (cmd[k] != 2'd0) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [1:0] c, input logic [XW-1:0] a, input logic [63:0] d);
        cmd[k]  = c;
        addr[k] = a;
        data[k] = d;
        size[k] = 2'd3;
        done[k] = 0;
    endtask

    // Inputs are already applied; check at the falling edge, then advance the model.
    task automatic step(input logic rst_n);
        int g, cnt;
        bit acc;
        logic [63:0] e_cmd, e_addr, e_data, e_size, e_resp, e_tag;
        reset = rst_n;
        #4;
        g   = model_grant();
        acc = (g >= 0) && (cmd[g] != 2'd0) && (mem_resp != '0);
        e_cmd = 0; e_addr = 0; e_data = 0; e_size = 0;
        if (g >= 0 && cmd[g] != 2'd0) begin
            e_cmd = 64'(cmd[g]); e_addr = 64'(addr[g]); e_data = data[g]; e_size = 64'(size[g]);
        end
        check_value("p2m_cmd", 64'(proc2mem_command), e_cmd);
        check_value("p2m_addr", 64'(proc2mem_addr), e_addr);
        check_value("p2m_data", proc2mem_data, e_data);
        check_value("p2m_size", 64'(proc2mem_size), e_size);
        for (int k = 0; k < 3; k++) begin
            e_resp = (acc && g == k) ? 64'(mem_resp) : 64'd0;
            e_tag  = (mem_tag != '0 && m_valid[mem_tag] && m_owner[mem_tag] == k) ? 64'(mem_tag) : 64'd0;
            check_value($sformatf("rsp_response_%0d", k), 64'(rsp_response[k]), e_resp);
            check_value($sformatf("rsp_tag_%0d", k), 64'(rsp_tag[k]), e_tag);
            check_value($sformatf("rsp_data_%0d", k), rsp_data[k], mem_data);
        end
        cnt = 0;
        foreach (m_valid[t]) cnt += int'(m_valid[t]);
        check_value("outstanding", 64'(outstanding), 64'(cnt));
        check_value("spurious_tag", 64'(spurious_tag), 64'(m_spur));
        @(posedge clock);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mem_tag != '0) begin
                if (m_valid[mem_tag]) m_valid[mem_tag] = 0;
                else m_spur = 1;
            end
            if (acc) begin
                $display("accept req=%0d cmd=%0d tag=%0d", g, cmd[g], mem_resp);
                if (cmd[g] == 2'd1) begin
                    m_valid[mem_resp] = 1;
                    m_owner[mem_resp] = g;
                end
                m_last = g;
                m_lock = -1;
                done[g] = 1;
            end else if (g >= 0 && cmd[g] != 2'd0) begin
                m_lock = g;
            end else begin
                m_lock = -1;
            end
        end
        #1;
    endtask

    task automatic drive_random(output logic rst_n);
        int r, t;
        int q[$];
        for (int k = 0; k < 3; k++) begin
            if (cmd[k] == 2'd0 || done[k]) begin
                done[k] = 0;
                if ($urandom_range(0, 1) == 1)
                    set_req(k, 2'($urandom_range(1, 2)), $urandom, {$urandom, $urandom});
                else
                    cmd[k] = 2'd0;
                size[k] = 2'($urandom_range(0, 3));
            end
        end
        mem_tag  = '0;
        mem_data = {$urandom, $urandom};
        r = $urandom_range(0, 99);
        if (r < 40) begin
            foreach (m_valid[i]) if (m_valid[i]) q.push_back(i);
            if (q.size() > 0) mem_tag = TAG_W'(q[$urandom_range(0, q.size() - 1)]);
        end else if (r < 43) begin
            t = $urandom_range(1, NTAG - 1);
            if (!m_valid[t]) mem_tag = TAG_W'(t);
        end
        mem_resp = '0;
        if ($urandom_range(0, 9) < 6) begin
            if (mem_tag != '0 && $urandom_range(0, 3) == 0) begin
                mem_resp = mem_tag;
            end else begin
                for (int n = 0; n < 20; n++) begin
                    t = $urandom_range(1, NTAG - 1);
                    if (!m_valid[t] || t == int'(mem_tag)) begin
                        mem_resp = TAG_W'(t);
                        break;
                    end
                end
            end
        end
        rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
        if (!rst_n) mem_resp = '0;
    endtask

    initial begin
        logic rst_n;
        for (int k = 0; k < 3; k++) begin
            set_req(k, 2'd0, '0, '0);
            size[k] = 2'd0;
        end
        mem_resp = '0; mem_tag = '0; mem_data = '0;
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        step(1'b1);  // reset state: idle port, nothing outstanding

        // all three load at once: accepted in order 0,1,2 with tags 1,2,3
        set_req(0, 2'd1, 32'h100, 64'h10);
        set_req(1, 2'd1, 32'h200, 64'h20);
        set_req(2, 2'd1, 32'h300, 64'h30);
        mem_resp = 4'd1; step(1'b1); cmd[0] = 2'd0;
        mem_resp = 4'd2; step(1'b1); cmd[1] = 2'd0;
        mem_resp = 4'd3; step(1'b1); cmd[2] = 2'd0;
        mem_resp = 4'd0; step(1'b1);
        check_value("three_loads_outstanding", 64'(outstanding), 64'd3);

        // completion of tag 2 goes only to requester 1
        mem_tag = 4'd2; mem_data = 64'hABCD; step(1'b1);
        mem_tag = 4'd0; step(1'b1);
        check_value("after_complete_outstanding", 64'(outstanding), 64'd2);

        // tag 7 is unowned: sticky flag
        mem_tag = 4'd7; step(1'b1);
        mem_tag = 4'd0;
        repeat (10) step(1'b1);
        check_value("spurious_sticky", 64'(spurious_tag), 64'd1);

        // store held off four cycles; requester 2 joins in cycle 2 but must wait
        set_req(1, 2'd2, 32'h8, 64'h55);
        step(1'b1);
        set_req(2, 2'd1, 32'h40, 64'h77);
        repeat (3) step(1'b1);
        mem_resp = 4'd5; step(1'b1); cmd[1] = 2'd0;
        mem_resp = 4'd0; step(1'b1);
        check_value("held_then_next", 64'(proc2mem_addr), 64'h40);
        mem_resp = 4'd6; step(1'b1); cmd[2] = 2'd0;
        mem_resp = 4'd0;

        // complete tag 1 (owner 0) and re-allocate it to requester 1 in the same cycle
        set_req(1, 2'd1, 32'h80, 64'h1);
        mem_tag = 4'd1; mem_resp = 4'd1; step(1'b1); cmd[1] = 2'd0;
        mem_tag = 4'd0; mem_resp = 4'd0; step(1'b1);
        mem_tag = 4'd1; step(1'b1);
        mem_tag = 4'd0;

        // reset while holding with loads outstanding
        set_req(0, 2'd1, 32'h8, 64'h9);
        step(1'b1);
        step(1'b0);
        cmd[0] = 2'd0;
        step(1'b1);
        check_value("reset_drops_outstanding", 64'(outstanding), 64'd0);
        mem_tag = 4'd3; step(1'b1);
        mem_tag = 4'd0; step(1'b1);
        check_value("stale_completion_spurious", 64'(spurious_tag), 64'd1);

        for (int n = 0; n < 3000; n++) begin
            drive_random(rst_n);
            step(rst_n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
